// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS CPU: default reset/halt addresses,
// the fetch-unit state encoding and the bus-to-CPU byte-order helper.
package mips_pkg;

   // Default first fetch address after reset (kseg1 boot ROM).
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

   // Default next-fetch address that stops the CPU (a jump to 0 ends the program).
   localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h00000000;

   // Every bus access is a full 32-bit word.
   localparam logic [3:0] BYTEENABLE_WORD = 4'hF;

   // Fetch addresses are always word aligned; low two bits of targets are dropped.
   localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFFFFFC;

   // Sequential instruction stride in bytes.
   localparam logic [31:0] INSTR_STRIDE = 32'd4;

   // Fetch unit states: one idle cycle after reset, read, present, stopped.
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   // Bus byte lanes are little-endian; the CPU wants the opposite order.
   // Also used on the data-memory path.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/mips_fetch_unit.sv
// Instruction fetch master for the multicycle MIPS CPU.
//
// Issues one Avalon-MM read at a time from fetch_pc, byte-swaps the returned
// word and presents it to the decoder until it is accepted.
//
// Handshake rule: an instruction transfers in a cycle where instr_valid and
// instr_ready are both high. While instr_valid is high, instruction and
// instr_pc stay stable. instr_valid never depends on instr_ready.
//
// Redirect rule: redirect_valid/redirect_target are sampled only in a
// handshake cycle. The instruction that follows the branch (the delay slot)
// is always fetched and handed over. Only after that does fetch continue at
// the target. A redirect seen while handing over a delay slot is ignored,
// because a branch in a delay slot is not supported.
//
// Reaching HALT_ADDR as the next fetch address parks the unit until reset.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   // Avalon-MM instruction read master
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   // Decoder side
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   // Status
   output logic        active
);

   fetch_state_t state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  target_q, target_d;
   logic         pending_q, pending_d;
   logic [31:0]  instruction_q, instruction_d;
   logic [31:0]  instr_pc_q, instr_pc_d;

   logic         handshake;
   logic [31:0]  seq_pc;
   logic [31:0]  next_pc;

   // State and datapath registers; reset restarts fetch at the reset vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_START;
         fetch_pc_q    <= RESET_VECTOR;
         target_q      <= 32'd0;
         pending_q     <= 1'b0;
         instruction_q <= 32'd0;
         instr_pc_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         target_q      <= target_d;
         pending_q     <= pending_d;
         instruction_q <= instruction_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   // Next-state and Moore outputs; every target is defaulted to "hold" first.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      target_d      = target_q;
      pending_d     = pending_q;
      instruction_d = instruction_q;
      instr_pc_d    = instr_pc_q;
      avm_read      = 1'b0;
      instr_valid   = 1'b0;
      active        = 1'b0;
      handshake     = 1'b0;
      // Sequential successor wraps naturally at 2^32.
      seq_pc        = instr_pc_q + INSTR_STRIDE;
      next_pc       = seq_pc;

      case (state_q)
         ST_START: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            avm_read = 1'b1;
            active   = 1'b1;
            if (!avm_waitrequest) begin
               instruction_d = byte_swap(avm_readdata);
               instr_pc_d    = fetch_pc_q;
               state_d       = ST_HOLD;
            end
         end

         ST_HOLD: begin
            instr_valid = 1'b1;
            active      = 1'b1;
            handshake   = instr_ready;
            if (handshake) begin
               if (pending_q) begin
                  // This was the delay slot: now take the saved branch target.
                  next_pc   = target_q;
                  pending_d = 1'b0;
               end else if (redirect_valid) begin
                  // Taken branch: remember target, fetch the delay slot first.
                  pending_d = 1'b1;
                  target_d  = redirect_target & WORD_ADDR_MASK;
               end
               fetch_pc_d = next_pc;
               state_d    = (next_pc == HALT_ADDR) ? ST_HALT : ST_FETCH;
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_START;
         end
      endcase
   end

   assign avm_address    = fetch_pc_q;
   assign avm_byteenable = BYTEENABLE_WORD;
   assign instruction    = instruction_q;
   assign instr_pc       = instr_pc_q;

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch master for the multicycle MIPS CPU. Reads instruction words over the Avalon-MM memory bus, byte-swaps them to CPU order, and hands them to the control unit/decoder with a valid/ready handshake. It owns the fetch PC, honours the branch delay slot when the decoder/execute side issues a redirect, and stops fetching when execution reaches the halt address.

## Interface
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset
- HALT_ADDR, 32'h00000000, next-fetch address that halts the CPU
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- avm_address  out  32  fetch address (word aligned)
- avm_read  out  1  read request
- avm_byteenable  out  4  constant 4'hF
- avm_waitrequest  in  1  slave stall; read completes in a cycle with avm_read=1, avm_waitrequest=0
- avm_readdata  in  32  bus data (little-endian byte lanes), valid in the completing cycle
- instruction  out  32  byte-swapped instruction word to decoder
- instr_pc  out  32  address the current instruction was fetched from
- instr_valid  out  1  instruction/instr_pc valid
- instr_ready  in  1  decoder accepts; handshake = instr_valid & instr_ready
- redirect_valid  in  1  accepted instruction is a taken branch/jump; sampled only in handshake cycles
- redirect_target  in  32  branch/jump target, sampled with redirect_valid
- active  out  1  high while CPU is running (not in START or HALT)

## Operation
- States: START, FETCH, HOLD, HALT.
- Reset (async, immediate): state=START, fetch_pc=RESET_VECTOR, avm_read=0, instr_valid=0, active=0, instruction=0, instr_pc=0, pending=0, target_q=0. avm_address shows fetch_pc in every state.
- START: one cycle, -> FETCH unconditionally.
- FETCH: avm_read=1, avm_address=fetch_pc, active=1. avm_address/avm_read held stable while avm_waitrequest=1. On completion: instruction <= {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}, instr_pc <= fetch_pc, -> HOLD.
- HOLD: instr_valid=1, avm_read=0; instruction/instr_pc stable until handshake. On handshake compute next:
  - pending=1 (this instruction is the delay slot): next=target_q, pending<=0; redirect_valid in this cycle ignored (branch in delay slot unsupported, no flag).
  - else redirect_valid=1: pending<=1, target_q<=redirect_target, next=instr_pc+4 (delay slot fetched next).
  - else next=instr_pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0).
  - fetch_pc<=next; next==HALT_ADDR -> HALT, else -> FETCH.
- HALT: avm_read=0, instr_valid=0, active=0; exits only by reset.
- redirect_target low two bits ignored (forced 2'b00).

## Timing
- Reset release: first avm_read=1 on second rising edge after rst_n rises (START cycle, then FETCH).
- Zero-wait read: FETCH 1 cycle, instr_valid high the following cycle.
- Best-case throughput: one instruction per 2 cycles (FETCH, HOLD with instr_ready=1).
- Each waitrequest cycle adds one cycle; instr_ready low extends HOLD one cycle each.
- No read is issued in HOLD, HALT or START; at most one outstanding read.
- Redirect takes effect after exactly one further instruction (delay slot) has been handed over.
- rst_n low mid-read: avm_read drops combinationally from state; transaction abandoned, restart at RESET_VECTOR.

## Structure
- Shared mips_pkg: RESET_VECTOR/HALT_ADDR defaults, fetch state enum, byte-swap function (reused by the data-memory path).
- Single module; no sub-module is natural (one FSM plus fetch_pc, target_q, pending, instruction registers).

## Test plan
- Reset, waitrequest=0, readdata=32'h78563412 -> avm_address=32'hBFC00000 at first read; instruction=32'h12345678, instr_pc=32'hBFC00000; next read at 32'hBFC00004.
- waitrequest high 3 cycles during fetch -> avm_address/avm_read stable 4 cycles, instr_valid one cycle after completion.
- instr_ready low 5 cycles in HOLD -> instruction stable, no avm_read until handshake.
- Handshake at instr_pc=32'hBFC00010 with redirect_valid=1, target=32'hBFC00100 -> next fetches 32'hBFC00014 (delay slot) then 32'hBFC00100.
- Redirect to 32'h00000000 (jr $0) -> delay slot delivered, then HALT: active=0, avm_read=0 indefinitely.
- rst_n pulsed low during a stalled read -> avm_read=0 immediately; after release fetch restarts at 32'hBFC00000, pending cleared.
